// File: rtl/minisys_pkg.sv
// Shared Minisys register-file widths and the write-port arbiter state encoding.
package minisys_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      FORCE = 2'd2
   } arb_state_t;

endpackage

// File: rtl/wb_port_arbiter.sv
// Shares the register file write port between pipeline writeback and the long unit,
// with a bounded wait so the long unit cannot be starved.
//
// state | meaning
// IDLE  | no long result losing arbitration; wb has priority
// WAIT  | long result lost at least once; wait_cnt counts consecutive losses
// FORCE | wb frozen this cycle, long result written unconditionally
module wb_port_arbiter
   import minisys_pkg::*;
#(
   parameter int LU_MAX_WAIT = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wb_req,
   input  logic [REG_ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0]     wb_data,
   input  logic                  lu_req,
   input  logic [REG_ADDR_W-1:0] lu_addr,
   input  logic [DATA_W-1:0]     lu_data,
   output logic                  wb_hold,
   output logic                  lu_ack,
   output logic                  rf_we,
   output logic [REG_ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0]     rf_wdata
);

   localparam logic [3:0] MAX_W = 4'(LU_MAX_WAIT);

   arb_state_t state, next_state;
   logic [3:0] wait_cnt, wait_nxt;
   logic       grant_wb, grant_lu;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         wait_cnt <= 4'd0;
      end else begin
         state    <= next_state;
         wait_cnt <= wait_nxt;
      end
   end

   always_comb begin
      next_state = state;
      wait_nxt   = wait_cnt;
      case (state)
         IDLE: begin
            if (lu_req && wb_req) begin
               wait_nxt   = 4'd1;
               next_state = (MAX_W <= 4'd1) ? FORCE : WAIT;
            end
         end
         WAIT: begin
            // A dropped lu_req is a protocol violation; recover to a clean IDLE.
            if (!lu_req || !wb_req) begin
               next_state = IDLE;
               wait_nxt   = 4'd0;
            end else begin
               wait_nxt = wait_cnt + 4'd1;
               if (wait_nxt >= MAX_W)
                  next_state = FORCE;
            end
         end
         FORCE: begin
            next_state = IDLE;
            wait_nxt   = 4'd0;
         end
         default: begin
            next_state = IDLE;
            wait_nxt   = 4'd0;
         end
      endcase
   end

   always_comb begin
      wb_hold  = 1'b0;
      grant_wb = 1'b0;
      grant_lu = 1'b0;
      case (state)
         FORCE: begin
            wb_hold  = 1'b1;
            grant_lu = lu_req;
         end
         default: begin
            grant_wb = wb_req;
            grant_lu = lu_req && !wb_req;
         end
      endcase
   end

   always_comb begin
      rf_waddr = REG_ZERO;
      rf_wdata = '0;
      if (grant_lu) begin
         rf_waddr = lu_addr;
         rf_wdata = lu_data;
      end else if (grant_wb) begin
         rf_waddr = wb_addr;
         rf_wdata = wb_data;
      end
   end

   assign lu_ack = grant_lu;
   assign rf_we  = (grant_lu || grant_wb) && (rf_waddr != REG_ZERO);

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler: scoreboard of long-op destinations, outstanding-op counter,
// issue hazard stall and the shared register file write port.
module regfile_wb_scheduler
   import minisys_pkg::*;
#(
   parameter int LU_MAX_WAIT     = 4,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  issue_valid,
   input  logic [REG_ADDR_W-1:0] issue_rs,
   input  logic [REG_ADDR_W-1:0] issue_rt,
   input  logic [REG_ADDR_W-1:0] issue_dst,
   input  logic                  issue_long,
   output logic                  issue_stall,
   input  logic                  wb_req,
   input  logic [REG_ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0]     wb_data,
   output logic                  wb_hold,
   input  logic                  lu_req,
   input  logic [REG_ADDR_W-1:0] lu_addr,
   input  logic [DATA_W-1:0]     lu_data,
   output logic                  lu_ack,
   output logic                  rf_we,
   output logic [REG_ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0]     rf_wdata,
   output logic                  sb_err
);

   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

   logic [31:0]      pending, pending_nxt;
   logic [CNT_W-1:0] outstanding;
   logic             accept_long, cnt_inc, cnt_dec, underflow, ack_err;

   wb_port_arbiter #(.LU_MAX_WAIT(LU_MAX_WAIT)) u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .wb_req   (wb_req),
      .wb_addr  (wb_addr),
      .wb_data  (wb_data),
      .lu_req   (lu_req),
      .lu_addr  (lu_addr),
      .lu_data  (lu_data),
      .wb_hold  (wb_hold),
      .lu_ack   (lu_ack),
      .rf_we    (rf_we),
      .rf_waddr (rf_waddr),
      .rf_wdata (rf_wdata)
   );

   // No bypass: a register cleared this cycle still stalls until the next one.
   assign issue_stall = issue_valid &&
                        (pending[issue_rs] || pending[issue_rt] || pending[issue_dst] ||
                         (issue_long && outstanding == CNT_MAX));

   assign accept_long = issue_valid && !issue_stall && issue_long;
   assign cnt_inc     = accept_long;
   assign cnt_dec     = lu_ack;
   assign underflow   = cnt_dec && !cnt_inc && (outstanding == '0);
   assign ack_err     = lu_ack && (lu_addr != REG_ZERO) && !pending[lu_addr];

   always_comb begin
      pending_nxt = pending;
      if (lu_ack)
         pending_nxt[lu_addr] = 1'b0;
      if (accept_long && issue_dst != REG_ZERO)
         pending_nxt[issue_dst] = 1'b1;
      pending_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending     <= '0;
         outstanding <= '0;
         sb_err      <= 1'b0;
      end else begin
         pending <= pending_nxt;
         if (cnt_inc && !cnt_dec)
            outstanding <= outstanding + 1'b1;
         else if (cnt_dec && !cnt_inc && outstanding != '0)
            outstanding <= outstanding - 1'b1;
         if (underflow || ack_err)
            sb_err <= 1'b1;
      end
   end

endmodule
